// File: rtl/ro_measure_ctrl.sv
// Measurement sequencer for the ring-oscillator frequency counter.
// Powers the oscillator, clears the up-counter, gates it for a programmable
// window, extends the count across counter wraps and captures one result per
// measurement, once or back-to-back.
module ro_measure_ctrl #(
  parameter int unsigned GATE_W        = 16,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned EXT_W         = 8,
  parameter int unsigned WARM_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     continuous,
  input  logic [GATE_W-1:0]        gate_len,
  input  logic [CNT_W-1:0]         cnt_val,
  output logic                     ro_en,
  output logic                     cnt_clr,
  output logic                     cnt_en,
  output logic                     busy,
  output logic [CNT_W+EXT_W-1:0]   result,
  output logic                     result_valid,
  output logic                     overflow
);

  localparam int unsigned RES_W   = CNT_W + EXT_W;
  localparam int unsigned WarmW   = $clog2(WARM_CYCLES + 1);
  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW0     = (GATE_W > WarmW) ? GATE_W : WarmW;
  // One down-counter times warm-up, gate and settle phases.
  localparam int unsigned TW      = (TW0 > SettleW) ? TW0 : SettleW;

  typedef enum logic [2:0] {
    StIdle,
    StWarm,
    StClear,
    StGate,
    StSettle,
    StCapture
  } state_e;

  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [GATE_W-1:0]  gate_q, gate_d;
  logic [EXT_W-1:0]   ext_q, ext_d;
  logic               flag_q, flag_d;
  logic               msb_q, msb_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               ro_en_q, busy_q, clr_q, en_q, valid_q;
  logic [GATE_W-1:0]  gate_fix;
  logic               track;
  logic               wrap;

  // A zero gate length would never close the window; run it as one cycle.
  assign gate_fix = (gate_len == '0) ? GATE_W'(1) : gate_len;

  // Next-state, wrap extension and capture logic.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    gate_d   = gate_q;
    ext_d    = ext_q;
    flag_d   = flag_q;
    msb_d    = msb_q;
    result_d = result_q;
    ovf_d    = ovf_q;

    // Counter keeps moving into SETTLE, so wraps are tracked there too.
    track = (state_q == StGate) || (state_q == StSettle);
    wrap  = track && msb_q && !cnt_val[CNT_W-1];
    if (track) begin
      msb_d = cnt_val[CNT_W-1];
    end
    if (wrap) begin
      if (&ext_q) begin
        flag_d = 1'b1;
      end else begin
        ext_d = ext_q + EXT_W'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWarm;
          gate_d  = gate_fix;
          timer_d = TW'(WARM_CYCLES - 1);
        end
      end
      StWarm: begin
        if (timer_q == '0) begin
          state_d = StClear;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      StClear: begin
        ext_d   = '0;
        flag_d  = 1'b0;
        msb_d   = 1'b0;
        state_d = StGate;
        timer_d = TW'(gate_q) - TW'(1);
      end
      StGate: begin
        if (timer_q == '0) begin
          state_d = StSettle;
          timer_d = TW'(SETTLE_CYCLES - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      StSettle: begin
        if (timer_q == '0) begin
          state_d  = StCapture;
          // Use next-state ext/flag so a wrap on this very edge is counted.
          result_d = flag_d ? {RES_W{1'b1}} : {ext_d, cnt_val};
          ovf_d    = flag_d;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      StCapture: begin
        if (continuous) begin
          state_d = StClear;
          gate_d  = gate_fix;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, datapath and registered strobe outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      gate_q   <= '0;
      ext_q    <= '0;
      flag_q   <= 1'b0;
      msb_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      ro_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      clr_q    <= 1'b0;
      en_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      gate_q   <= gate_d;
      ext_q    <= ext_d;
      flag_q   <= flag_d;
      msb_q    <= msb_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      ro_en_q  <= (state_d != StIdle);
      busy_q   <= (state_d != StIdle);
      clr_q    <= (state_d == StClear);
      en_q     <= (state_d == StGate);
      valid_q  <= (state_d == StCapture);
    end
  end

  assign ro_en        = ro_en_q;
  assign busy         = busy_q;
  assign cnt_clr      = clr_q;
  assign cnt_en       = en_q;
  assign result_valid = valid_q;
  assign result       = result_q;
  assign overflow     = ovf_q;

endmodule

// File: doc/ro_measure_ctrl.md
# ro_measure_ctrl

Measurement sequencer for the ring-oscillator frequency counter. It powers the ring oscillator, clears the 8-bit up-counter, and holds the counter enable for a programmable gate window of reference-clock cycles. It then lets the counter settle, tracks counter wrap-arounds to extend the count width, and presents one captured result per measurement, either once or continuously. It sits between the host/register interface and the up-counter instance in the oscillator datapath.

## Interface
Parameters:
- GATE_W, 16, width of the gate-length input.
- CNT_W, 8, width of the up-counter output.
- EXT_W, 8, wrap-extension bits above the counter value.
- WARM_CYCLES, 4, ring-oscillator warm-up cycles before the first gate (≥1).
- SETTLE_CYCLES, 4, cycles with the counter disabled before capture (≥1).

Ports:
- clk  in  1  reference clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  measurement request; sampled only in IDLE.
- continuous  in  1  when high at CAPTURE, the next measurement starts without returning to IDLE.
- gate_len  in  GATE_W  gate window in clk cycles; latched on accepted start and at each continuous restart.
- cnt_val  in  CNT_W  up-counter output, already in the clk domain.
- ro_en  out  1  ring-oscillator enable.
- cnt_clr  out  1  counter clear, drives the counter reset.
- cnt_en  out  1  counter enable.
- busy  out  1  high in every state except IDLE.
- result  out  CNT_W+EXT_W  last captured count {ext, cnt_val}.
- result_valid  out  1  one-cycle pulse when result updates.
- overflow  out  1  high with result when the extension saturated; held until the next capture.

## Operation
- States: IDLE, WARM, CLEAR, GATE, SETTLE, CAPTURE.
- IDLE: all strobes low. start=1 → WARM, latch gate_len, where 0 is treated as 1.
- WARM: ro_en=1 for WARM_CYCLES cycles → CLEAR.
- CLEAR: cnt_clr=1 for 1 cycle; ext and the overflow flag clear → GATE.
- GATE: cnt_en=1 for the latched gate_len cycles → SETTLE.
- SETTLE: cnt_en=0 for SETTLE_CYCLES cycles → CAPTURE.
- CAPTURE (1 cycle): result_valid=1. If continuous=1 → CLEAR with gate_len re-latched and ro_en held. Otherwise → IDLE.
- ro_en stays high from WARM through CAPTURE and goes low only in IDLE.
- Wrap tracking:
  - Applies on every edge in GATE or SETTLE.
  - A wrap is prev_msb=1 with cnt_val[CNT_W-1]=0; prev_msb is the registered MSB of cnt_val and is cleared in CLEAR.
  - On a wrap, ext increments.
  - If ext is all-ones when a wrap occurs, ext holds and the overflow flag sets.
- The counter advances at most 2^(CNT_W-1)-1 per clk; wrap detection is valid only under this limit.
- Capture, on the edge leaving SETTLE:
  - result ← {ext_next, cnt_val}, where ext_next includes any wrap detected on that same edge.
  - overflow ← flag.
  - If the flag is set, result ← all-ones.
- start is ignored while busy. Deasserting continuous mid-measurement completes the current measurement, then goes to IDLE.
- Reset, in any state, on the next edge:
  - State goes to IDLE.
  - ro_en, cnt_clr, cnt_en, busy, result_valid, overflow go to 0; result and ext go to 0.
  - A measurement in flight is discarded with no result_valid.

## Timing
- All outputs are registered and decoded from the state register.
- Start sampled at edge E0: WARM occupies cycles 1..W, CLEAR cycle W+1, GATE cycles W+2..W+1+G, SETTLE the next S cycles.
- result_valid is high in cycle W+G+S+2; result and overflow are stable from that cycle.
- Continuous mode: CLEAR follows CAPTURE directly, so the period is 1+G+S+1 cycles.
- busy rises the cycle after the start edge and falls the cycle after CAPTURE.
- cnt_en is high for exactly G edges per measurement; cnt_clr is high for exactly 1 cycle.

## Test plan
- Single shot: counter model increments on cnt_en; W=4, S=4, gate_len=10, start pulse. Required: result=10, overflow=0, result_valid 1 cycle at cycle 20 after the start edge, busy low the cycle after.
- Wrap: gate_len=300, single shot. Required: result=300 (ext=1, cnt_val=44), overflow=0.
- Overflow: EXT_W=1, gate_len=600. Required: result=511, overflow=1. A following gate_len=5 run: result=5, overflow=0.
- Continuous: continuous=1, gate_len=10; change gate_len to 20 after the first result. Required: result_valid pulses 16 cycles apart, then 26 cycles apart; results 10, then 20; ro_en never drops. Drop continuous: returns to IDLE after the current capture.
- Edge cases: gate_len=0 gives result=1. start during GATE is ignored, with exactly one result_valid.
- Reset mid-GATE: all outputs 0 the next cycle, no result_valid. A new start then gives a normal result.
